// File: rtl/pid_steering.sv
// Fixed-point PID steering: error frames in, differential wheel speeds out.
// Define PID_WATCHDOG_EN to enable the stale-input watchdog.
module pid_steering #(
    parameter int unsigned        FRAC_BITS  = 8,
    parameter logic signed [15:0] KP         = 16'sd512,
    parameter logic signed [15:0] KI         = 16'sd8,
    parameter logic signed [15:0] KD         = 16'sd256,
    parameter int                 ERR_CLAMP  = 160,
    parameter int                 INT_LIMIT  = 4096,
    parameter int                 OUT_MAX    = 127,
    parameter int                 BASE_SPEED = 128,
    parameter int                 SPEED_MAX  = 255
`ifdef PID_WATCHDOG_EN
    ,
    parameter int unsigned        WATCHDOG_CYCLES = 2500000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] error,
    input  logic               error_ready,
    output logic        [7:0]  left_speed,
    output logic        [7:0]  right_speed,
    output logic signed [15:0] steer,
    output logic               cmd_valid,
    output logic               busy,
    output logic               stale
);

    localparam logic signed [31:0] ErrLim32 = ERR_CLAMP;
    localparam logic signed [15:0] ErrLim16 = 16'(ERR_CLAMP);
    localparam logic signed [16:0] IntLim17 = 17'(INT_LIMIT);
    localparam logic signed [15:0] IntLim16 = 16'(INT_LIMIT);
    localparam logic signed [33:0] OutLim34 = 34'(OUT_MAX);
    localparam logic signed [15:0] OutLim16 = 16'(OUT_MAX);
    localparam logic signed [17:0] Base18   = 18'(BASE_SPEED);
    localparam logic signed [17:0] SpMax18  = 18'(SPEED_MAX);
    localparam logic        [7:0]  SpMax8   = 8'(SPEED_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMul,
        StSum,
        StSat,
        StOut
    } state_e;

    state_e             state_q;
    logic               ready_q;
    logic               first_q;
    logic signed [15:0] e_prev_q;
    logic signed [15:0] e_q;
    logic signed [15:0] d_q;
    logic signed [15:0] i_acc_q;
    logic signed [31:0] p_q;
    logic signed [31:0] i_q;
    logic signed [31:0] dp_q;
    logic signed [33:0] u_raw_q;

    logic               trigger;
    logic signed [15:0] e_clamped;
    logic signed [15:0] d_next;
    logic signed [16:0] i_sum;
    logic signed [15:0] i_next;
    logic signed [33:0] s_sum;
    logic signed [33:0] u_raw_next;
    logic signed [15:0] u_sat;
    logic signed [17:0] u_ext;
    logic signed [17:0] spd_l;
    logic signed [17:0] spd_r;
    logic        [7:0]  left_next;
    logic        [7:0]  right_next;

    // Only a fresh rising edge seen while idle starts a computation.
    assign trigger = (state_q == StIdle) && error_ready && !ready_q;
    assign busy    = (state_q != StIdle);

    always_comb begin
        e_clamped = error[15:0];
        if (error > ErrLim32) begin
            e_clamped = ErrLim16;
        end else if (error < -ErrLim32) begin
            e_clamped = -ErrLim16;
        end

        d_next = first_q ? 16'sd0 : (e_clamped - e_prev_q);

        i_sum  = $signed({i_acc_q[15], i_acc_q}) + $signed({e_clamped[15], e_clamped});
        i_next = i_sum[15:0];
        if (i_sum > IntLim17) begin
            i_next = IntLim16;
        end else if (i_sum < -IntLim17) begin
            i_next = -IntLim16;
        end
    end

    always_comb begin
        s_sum      = 34'(p_q) + 34'(i_q) + 34'(dp_q);
        u_raw_next = s_sum >>> FRAC_BITS;
    end

    always_comb begin
        u_sat = u_raw_q[15:0];
        if (u_raw_q > OutLim34) begin
            u_sat = OutLim16;
        end else if (u_raw_q < -OutLim34) begin
            u_sat = -OutLim16;
        end

        // Positive steer slows the left wheel and speeds up the right one.
        u_ext = {{2{u_sat[15]}}, u_sat};
        spd_l = Base18 - u_ext;
        spd_r = Base18 + u_ext;

        left_next = spd_l[7:0];
        if (spd_l < 18'sd0) begin
            left_next = 8'd0;
        end else if (spd_l > SpMax18) begin
            left_next = SpMax8;
        end

        right_next = spd_r[7:0];
        if (spd_r < 18'sd0) begin
            right_next = 8'd0;
        end else if (spd_r > SpMax18) begin
            right_next = SpMax8;
        end
    end

`ifdef PID_WATCHDOG_EN
    localparam int unsigned       WdW    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WdW-1:0]    WdMax  = WdW'(WATCHDOG_CYCLES);
    localparam logic [WdW-1:0]    WdLast = WdW'(WATCHDOG_CYCLES - 1);
    logic [WdW-1:0] wd_cnt_q;
`else
    assign stale = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            first_q     <= 1'b1;
            e_prev_q    <= '0;
            e_q         <= '0;
            d_q         <= '0;
            i_acc_q     <= '0;
            p_q         <= '0;
            i_q         <= '0;
            dp_q        <= '0;
            u_raw_q     <= '0;
            left_speed  <= '0;
            right_speed <= '0;
            steer       <= '0;
            cmd_valid   <= 1'b0;
`ifdef PID_WATCHDOG_EN
            stale       <= 1'b0;
            wd_cnt_q    <= '0;
`endif
        end else begin
            ready_q   <= error_ready;
            cmd_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    e_q      <= e_clamped;
                    d_q      <= d_next;
                    i_acc_q  <= i_next;
                    e_prev_q <= e_clamped;
                    first_q  <= 1'b0;
`ifdef PID_WATCHDOG_EN
                    stale    <= 1'b0;
`endif
                    state_q  <= StMul;
                end
                StMul: begin
                    p_q     <= 32'(e_q) * 32'(KP);
                    i_q     <= 32'(i_acc_q) * 32'(KI);
                    dp_q    <= 32'(d_q) * 32'(KD);
                    state_q <= StSum;
                end
                StSum: begin
                    u_raw_q <= u_raw_next;
                    state_q <= StSat;
                end
                StSat: begin
                    steer       <= u_sat;
                    left_speed  <= left_next;
                    right_speed <= right_next;
                    cmd_valid   <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
`ifdef PID_WATCHDOG_EN
            // Stale input: park the wheels and restart the controller from scratch.
            if (trigger) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WdMax) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
                if (wd_cnt_q == WdLast) begin
                    stale       <= 1'b1;
                    left_speed  <= '0;
                    right_speed <= '0;
                    steer       <= '0;
                    i_acc_q     <= '0;
                    first_q     <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_pid_steering.sv
// Directed self-checking bench for pid_steering.
module tb_pid_steering;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] error;
    logic               error_ready;
    logic        [7:0]  left_speed;
    logic        [7:0]  right_speed;
    logic signed [15:0] steer;
    logic               cmd_valid;
    logic               busy;
    logic               stale;

    int checks = 0;
    int errors = 0;

    pid_steering #(
        .FRAC_BITS(8)
`ifdef PID_WATCHDOG_EN
        ,
        .WATCHDOG_CYCLES(100)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .error      (error),
        .error_ready(error_ready),
        .left_speed (left_speed),
        .right_speed(right_speed),
        .steer      (steer),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset       = 1'b0;
        error_ready = 1'b0;
        error       = 32'sd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Raise error_ready one cycle, return the cycle index where cmd_valid appears.
    task automatic run_frame(input logic signed [31:0] err, output int lat);
        error = err;
        @(posedge clk);
        #1 error_ready = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid) begin
                lat = c;
                break;
            end
        end
        error_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input int exp_steer, input int exp_l,
                                 input int exp_r);
        checks++;
        if (steer !== 16'(exp_steer) || left_speed !== 8'(exp_l) || right_speed !== 8'(exp_r))
        begin
            errors++;
            $display("FAIL %s: got steer=%0d left=%0d right=%0d expected steer=%0d left=%0d right=%0d",
                     name, steer, left_speed, right_speed, exp_steer, exp_l, exp_r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        error_ready = 1'b0;
        error = 32'sd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({left_speed, right_speed, steer, cmd_valid, busy, stale} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%0d r=%0d s=%0d v=%b b=%b st=%b expected all 0",
                     left_speed, right_speed, steer, cmd_valid, busy, stale);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b valid=%b expected 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_zero_error();
        int lat;
        apply_reset();
        run_frame(32'sd0, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 5", lat);
        end
        check_outputs("zero_out", 0, 128, 128);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got valid=%b busy=%b expected 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_positive();
        int lat;
        apply_reset();
        run_frame(32'sd10, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL pos1_latency: got %0d expected 5", lat);
        end
        check_outputs("pos1_out", 20, 108, 148);
        run_frame(32'sd20, lat);
        check_outputs("pos2_out", 50, 78, 178);
    endtask

    task automatic test_negative();
        int lat;
        apply_reset();
        run_frame(-32'sd10, lat);
        check_outputs("neg_floor", -21, 149, 107);
    endtask

    task automatic test_saturation();
        int lat;
        apply_reset();
        run_frame(32'sd1000, lat);
        check_outputs("sat_pos", 127, 1, 255);
        for (int k = 0; k < 29; k++) begin
            run_frame(32'sd1000, lat);
        end
        check_outputs("sat_pos30", 127, 1, 255);
        // Integrator pinned at +4096: D=-40960, I=32768 -> steer -32.
        run_frame(32'sd0, lat);
        check_outputs("int_limit", -32, 160, 96);
        apply_reset();
        run_frame(-32'sd1000, lat);
        check_outputs("sat_neg", -127, 255, 1);
    endtask

    task automatic test_held_high();
        int pulses;
        apply_reset();
        error = 32'sd0;
        pulses = 0;
        @(posedge clk);
        #1 error_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid) pulses++;
        end
        error_ready = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL held_high: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_busy_edge();
        int pulses;
        int first_at;
        apply_reset();
        error = 32'sd10;
        pulses = 0;
        first_at = -1;
        @(posedge clk);
        #1 error_ready = 1'b1;
        @(posedge clk);
        #1 error_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 error_ready = 1'b1;
        for (int c = 3; c < 25; c++) begin
            if (cmd_valid) begin
                pulses++;
                if (first_at < 0) first_at = c;
            end
            @(posedge clk);
            #1;
        end
        error_ready = 1'b0;
        checks++;
        if (pulses !== 1 || first_at !== 5) begin
            errors++;
            $display("FAIL busy_edge: got %0d pulses first at %0d expected 1 at 5",
                     pulses, first_at);
        end
        check_outputs("busy_edge_out", 20, 108, 148);
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        apply_reset();
        run_frame(32'sd10, lat);
        error = 32'sd20;
        @(posedge clk);
        #1 error_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({left_speed, right_speed, steer, cmd_valid, busy} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid: got l=%0d r=%0d s=%0d v=%b b=%b expected all 0",
                     left_speed, right_speed, steer, cmd_valid, busy);
        end
        error_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_valid: got %0d pulses expected 0", pulses);
        end
        // Fresh state after abort: no derivative kick, integrator restarted.
        run_frame(32'sd10, lat);
        check_outputs("reset_mid_restart", 20, 108, 148);
    endtask

`ifdef PID_WATCHDOG_EN
    task automatic test_watchdog();
        int lat;
        apply_reset();
        run_frame(32'sd10, lat);
        repeat (110) @(posedge clk);
        #1;
        checks++;
        if (stale !== 1'b1) begin
            errors++;
            $display("FAIL wd_stale: got %b expected 1", stale);
        end
        check_outputs("wd_zero", 0, 0, 0);
        // Restarted controller: D=0, I_acc=20 -> s=10400, u=40.
        run_frame(32'sd20, lat);
        check_outputs("wd_restart", 40, 88, 168);
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL wd_clear: got %b expected 0", stale);
        end
    endtask
`endif

    initial begin
        reset       = 1'b0;
        error       = 32'sd0;
        error_ready = 1'b0;
        test_reset();
        test_zero_error();
        test_positive();
        test_negative();
        test_saturation();
        test_held_high();
        test_busy_edge();
        test_reset_mid();
`ifdef PID_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_steering.md
Name: pid_steering

Overview:
- Downstream consumer of the mid-line error stage.
- Takes the signed per-frame path-centre error plus its ready flag and runs a fixed-point PID with integrator anti-windup and output saturation.
- Produces differential left/right motor speed commands with a one-cycle valid pulse for the PWM/motor driver stage.

Parameters:
- FRAC_BITS, 8: fractional bits of gains (Q.8); sum is arithmetically shifted right by this.
- KP, 16'sd512: signed proportional gain (2.0).
- KI, 16'sd8: signed integral gain (0.03125).
- KD, 16'sd256: signed derivative gain (1.0).
- ERR_CLAMP, 160: input error clamped to ±ERR_CLAMP before use.
- INT_LIMIT, 4096: integrator accumulator clamped to ±INT_LIMIT.
- OUT_MAX, 127: steer term clamped to ±OUT_MAX.
- BASE_SPEED, 128: nominal speed for both wheels.
- SPEED_MAX, 255: upper clamp of wheel speeds (lower clamp 0).
- WATCHDOG_CYCLES, 2500000: stale-input timeout in clk cycles (50 ms @ 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- error  in  32 signed  path error = image centre − path centre.
- error_ready  in  1  level; may stay high until next frame start.
- left_speed  out  8  left wheel speed command.
- right_speed  out  8  right wheel speed command.
- steer  out  16 signed  saturated PID output u.
- cmd_valid  out  1  one-cycle pulse when new speeds are on the outputs.
- busy  out  1  high while the pipeline FSM is not IDLE.
- stale  out  1  watchdog expired (only with PID_WATCHDOG_EN; else tied 0).

Behaviour:
- Reset (async assert, sync release): all outputs 0. e_prev=0, I_acc=0, first_flag=1, FSM=IDLE, error_ready edge register=0.
- Trigger: rising edge of error_ready (registered previous value). Only an edge sampled in IDLE starts a computation. Edges while busy are dropped. A held-high level never retriggers.
- FSM IDLE→LOAD→MUL→SUM→SAT→OUT→IDLE; one cycle per state.
- Latency: edge seen at cycle 0 (IDLE), cmd_valid high in cycle 5. New edge accepted from cycle 6 on.
- LOAD:
  - e = clamp(error, ±ERR_CLAMP) as 16-bit signed.
  - d = first_flag ? 0 : e − e_prev.
  - I_acc = clamp(I_acc + e, ±INT_LIMIT), computed 17-bit, no wrap.
  - e_prev ← e; first_flag ← 0.
- MUL: P=KP·e, I=KI·I_acc, D=KD·d; 32-bit signed registered products.
- SUM: s = P+I+D in 34-bit signed; u_raw = s >>> FRAC_BITS (floor toward −inf).
- SAT: u = clamp(u_raw, ±OUT_MAX).
- OUT:
  - steer ← u.
  - left_speed ← clamp(BASE_SPEED − u, 0..SPEED_MAX).
  - right_speed ← clamp(BASE_SPEED + u, 0..SPEED_MAX).
  - cmd_valid=1 this cycle only.
  - Speed and steer outputs hold until the next OUT.
- Sign convention: positive error (path left of centre) makes right faster.
- Reset asserted mid-computation: immediate abort, all state and outputs to reset values, no cmd_valid.

Optional Feature:
- Macro PID_WATCHDOG_EN.
- With it:
  - A counter increments every cycle and clears on each accepted trigger.
  - On reaching WATCHDOG_CYCLES, stale=1 and left_speed=right_speed=0, steer=0.
  - I_acc is cleared and first_flag is set. No cmd_valid is generated.
  - Counter saturates.
  - The next accepted trigger clears stale in its LOAD cycle and computes normally.
- Without it: no counter, stale tied 0, outputs hold indefinitely.

Test Plan:
- Reset, then error=0 with rising error_ready → cmd_valid exactly 5 cycles later; left=right=128, steer=0.
- Fresh reset, error=+10 → P=5120, I=80, D=0, s=5200, u=20; left=108, right=148.
- Follow with error=+20 → I_acc=30, s=10240+240+2560=13040, u=50; left=78, right=178.
- Fresh reset, error=−10 → s=−5200, u=−21 (floor); left=149, right=107.
- error=+1000 → clamped e=160, u saturates to 127; left=1, right=255. I_acc stops at 4096 after repeated frames (≥26).
- error_ready held high 1000 cycles → one cmd_valid only; second edge during busy (cycle 3) → ignored. Reset asserted in MUL → no cmd_valid, outputs 0.
- PID_WATCHDOG_EN, WATCHDOG_CYCLES=100, no trigger for 100 cycles after a valid command → stale=1, speeds 0. Next edge → stale cleared, D=0 on that sample.
